// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - edge-counting frequency meter, result in Hz
// Optional FREQ_METER_HOLD_EN adds a hold input that freezes the published freq.
module freq_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int GATE_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clkbase,
  input  logic        enable,
`ifdef FREQ_METER_HOLD_EN
  input  logic        hold,
`endif
  input  logic        sig_in,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GATE = 1'b1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [0:0]             r_state;
  logic [31:0]            r_gate_len;
  logic [31:0]            r_gate_cnt;
  logic [31:0]            r_edge_cnt;
  logic [31:0]            r_freq;
  logic                   r_freq_valid;

  logic        w_synced;
  logic        w_edge_now;
  logic        w_hold;
  logic        w_start;
  logic        w_terminal;
  logic [31:0] w_gate_calc;
  logic [32:0] w_edge_sum;
  logic [31:0] w_edge_tot;
  logic [63:0] w_prod;
  logic [31:0] w_freq_next;

`ifdef FREQ_METER_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_synced    = r_sync[SYNC_STAGES-1];
  assign w_edge_now  = w_synced & ~r_prev;
  assign w_gate_calc = clkbase / 32'(GATE_DIV);
  assign w_start     = enable && (w_gate_calc != 32'd0);
  assign w_terminal  = (r_state == S_GATE) && (r_gate_cnt == r_gate_len - 32'd1);

  // The edge seen in the terminal cycle belongs to the closing window.
  assign w_edge_sum  = {1'b0, r_edge_cnt} + {32'd0, w_edge_now};
  assign w_edge_tot  = w_edge_sum[32] ? 32'hFFFF_FFFF : w_edge_sum[31:0];
  assign w_prod      = {32'd0, w_edge_tot} * 64'(GATE_DIV);
  assign w_freq_next = (|w_prod[63:32]) ? 32'hFFFF_FFFF : w_prod[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_state      <= S_IDLE;
      r_gate_len   <= 32'd0;
      r_gate_cnt   <= 32'd0;
      r_edge_cnt   <= 32'd0;
      r_freq       <= 32'd0;
      r_freq_valid <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev       <= w_synced;
      r_freq_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_gate_len <= w_gate_calc;
          r_gate_cnt <= 32'd0;
          r_edge_cnt <= 32'd0;
          r_state    <= S_GATE;
        end
      end else if (w_terminal) begin
        r_freq_valid <= 1'b1;
        if (!w_hold) r_freq <= w_freq_next;
        // Back-to-back windows: re-latch and clear in the same edge, no gap.
        r_gate_cnt <= 32'd0;
        r_edge_cnt <= 32'd0;
        if (w_start) r_gate_len <= w_gate_calc;
        else         r_state    <= S_IDLE;
      end else if (!enable) begin
        r_gate_cnt <= 32'd0;
        r_edge_cnt <= 32'd0;
        r_state    <= S_IDLE;
      end else begin
        r_gate_cnt <= r_gate_cnt + 32'd1;
        if (w_edge_now && (r_edge_cnt != 32'hFFFF_FFFF))
          r_edge_cnt <= r_edge_cnt + 32'd1;
      end
    end
  end

  assign freq       = r_freq;
  assign freq_valid = r_freq_valid;
  assign busy       = (r_state == S_GATE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed bench for freq_meter (GATE_DIV 1 and 4 instances)
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clkbase = 32'd1000;
  logic        enable = 1'b0;
  logic        enable4 = 1'b0;
  logic        hold = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] freq1, freq4;
  logic        fv1, fv4, busy1, busy4;

  int checks = 0;
  int errors = 0;
  int sig_period = 10;
  logic sig_level = 1'b0;
  int ph = 0;
  int n;
  bit idle;

  always #5 clk = ~clk;

  // Square wave, high for the first half of each period, updated away from posedge.
  always @(negedge clk) begin
    if (sig_period == 0) begin
      sig_in = sig_level;
    end else begin
      if (ph >= sig_period - 1) ph = 0;
      else ph = ph + 1;
      sig_in = (ph < sig_period / 2);
    end
  end

  freq_meter #(.SYNC_STAGES(2), .GATE_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clkbase(clkbase), .enable(enable),
`ifdef FREQ_METER_HOLD_EN
    .hold(hold),
`endif
    .sig_in(sig_in), .freq(freq1), .freq_valid(fv1), .busy(busy1)
  );

  freq_meter #(.SYNC_STAGES(2), .GATE_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clkbase(clkbase), .enable(enable4),
`ifdef FREQ_METER_HOLD_EN
    .hold(1'b0),
`endif
    .sig_in(sig_in), .freq(freq4), .freq_valid(fv4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges until the selected instance pulses freq_valid (bounded).
  task automatic wait_v(input bit sel4, input int budget, output int cnt, output bit saw_idle);
    cnt = 0;
    saw_idle = 1'b0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (!(sel4 ? busy4 : busy1)) saw_idle = 1'b1;
    end while (!(sel4 ? fv4 : fv1) && cnt < budget);
  endtask

  initial begin
    #1;
    check("reset_freq", freq1, 32'd0);
    check("reset_valid", {31'd0, fv1}, 32'd0);
    check("reset_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // clkbase of zero never starts a gate
    clkbase = 32'd0;
    enable  = 1'b1;
    idle = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy1 || fv1) idle = 1'b1;
    end
    check("zero_base_activity", {31'd0, idle}, 32'd0);
    check("zero_base_freq", freq1, 32'd0);

    // GATE_DIV=1, period 10: first valid gate_len+1 edges after enable, then every 1000
    @(negedge clk) clkbase = 32'd1000;
    wait_v(1'b0, 1100, n, idle);
    check("first_latency", n, 32'd1001);
    check("win1_freq", freq1, 32'd100);
    wait_v(1'b0, 1100, n, idle);
    check("win2_interval", n, 32'd1000);
    check("win2_freq", freq1, 32'd100);
    check("win2_busy_held", {31'd0, idle}, 32'd0);

    // GATE_DIV=4: windows of 250 cycles
    @(negedge clk) enable4 = 1'b1;
    wait_v(1'b1, 300, n, idle);
    check("div4_first_latency", n, 32'd251);
    check("div4_freq", freq4, 32'd100);
    wait_v(1'b1, 300, n, idle);
    check("div4_interval", n, 32'd250);
    check("div4_freq2", freq4, 32'd100);
    @(negedge clk) sig_period = 7;
    wait_v(1'b1, 300, n, idle);
    for (int i = 0; i < 3; i++) begin
      wait_v(1'b1, 300, n, idle);
      check("div4_p7_interval", n, 32'd250);
      check("div4_p7_freq", {31'd0, (freq4 == 32'd140 || freq4 == 32'd144)}, 32'd1);
    end
    @(negedge clk) begin enable4 = 1'b0; sig_period = 10; end
    wait_v(1'b0, 1100, n, idle);
    wait_v(1'b0, 1100, n, idle);
    check("p10_restore_freq", freq1, 32'd100);

    // Abort mid-gate: no valid, freq held, then clean restart
    repeat (500) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (fv1) idle = 1'b1;
    end
    check("abort_no_valid", {31'd0, idle}, 32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_freq_held", freq1, 32'd100);
    @(negedge clk) enable = 1'b1;
    wait_v(1'b0, 1100, n, idle);
    check("restart_latency", n, 32'd1001);
    check("restart_freq", freq1, 32'd100);

    // Constant-high input gives zero
    @(negedge clk) begin sig_period = 0; sig_level = 1'b1; end
    wait_v(1'b0, 1100, n, idle);
    wait_v(1'b0, 1100, n, idle);
    check("const_high_freq", freq1, 32'd0);
    @(negedge clk) sig_period = 10;
    wait_v(1'b0, 1100, n, idle);
    wait_v(1'b0, 1100, n, idle);
    check("pre_reset_freq", freq1, 32'd100);

    // Asynchronous reset mid-gate
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_freq", freq1, 32'd0);
    check("async_rst_valid", {31'd0, fv1}, 32'd0);
    check("async_rst_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

`ifdef FREQ_METER_HOLD_EN
    wait_v(1'b0, 1100, n, idle);
    wait_v(1'b0, 1100, n, idle);
    check("hold_pre_freq", freq1, 32'd100);
    @(negedge clk) begin hold = 1'b1; sig_period = 20; end
    for (int i = 0; i < 3; i++) begin
      wait_v(1'b0, 1100, n, idle);
      check("hold_valid_interval", n, 32'd1000);
      check("hold_freq_frozen", freq1, 32'd100);
    end
    @(negedge clk) hold = 1'b0;
    wait_v(1'b0, 1100, n, idle);
    check("unhold_interval", n, 32'd1000);
    check("unhold_freq", freq1, 32'd50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
